path_readback_ctrl: RTL and testbench
=====================================

// Module: path_readback_ctrl
// PURPOSE
//  Sequences readback of the computed path from the RISC-V CPU data memory external port after SP/EP load.
//  - Polls the CPU done word, then reads the path length and each path node.
//  - Streams nodes out over a valid/ready interface to downstream (bot motion / UART).
//  - Shares the external memory port with the point loader through a req/gnt pair.
// PARAMETERS
//  BASE_ADR    32'h02000000  base of CPU mailbox region
//  LEN_OFS     32'h8         offset of path-length word (CPU-written)
//  DONE_OFS    32'hC         offset of done word (nonzero = CPU finished)
//  PATH_OFS    32'h10        offset of node 0; node i at BASE_ADR+PATH_OFS+4*i
//  MAX_NODES   32            largest legal path length
//  POLL_GAP    16            idle cycles between done polls
//  MAX_POLLS   1024          polls before timeout error
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  start          in   1   1-cycle pulse: begin readback (ignored unless IDLE/DONE/ERR)
//  abort          in   1   return to IDLE next edge, drops mem_req
//  mem_req        out  1   request for external memory port
//  mem_gnt        in   1   port granted this cycle
//  Ext_ReadEn     out  1   read strobe, only asserted while mem_gnt=1
//  Ext_DataAdr    out  32  read address (0 when Ext_ReadEn=0)
//  Ext_ReadData   in   32  read data, valid exactly 1 cycle after Ext_ReadEn&mem_gnt
//  node_valid     out  1   node_data valid
//  node_ready     in   1   downstream accepts on node_valid&node_ready
//  node_data      out  5   path node id (Ext_ReadData[4:0])
//  node_last      out  1   marks final node
//  path_len       out  6   latched path length
//  busy           out  1   not in IDLE/DONE/ERR
//  done           out  1   level, set on successful completion, cleared by start
//  error          out  1   level, set on timeout/length overflow, cleared by start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Async reset mid-transfer aborts cleanly.
//  FSM: IDLE -start-> POLL_REQ.
//   POLL_REQ: mem_req=1; on mem_gnt, ReadEn=1, Adr=BASE+DONE_OFS -> POLL_WAIT.
//   POLL_WAIT: sample data; nonzero -> LEN_REQ; zero -> GAP (mem_req=0, POLL_GAP cycles) -> POLL_REQ.
//    poll count reaching MAX_POLLS -> ERR.
//   LEN_REQ/LEN_WAIT: same handshake at BASE+LEN_OFS; latch path_len=data[5:0].
//    len==0 -> DONE (no nodes emitted); data>MAX_NODES -> ERR; else idx=0 -> NODE_REQ.
//   NODE_REQ/NODE_WAIT: read BASE+PATH_OFS+4*idx; register into node_data -> NODE_OUT.
//   NODE_OUT: mem_req=0; node_valid=1, node_last=(idx==path_len-1); hold data until ready.
//    on accept: last -> DONE else idx++ -> NODE_REQ.
//   DONE: done=1, busy=0. ERR: error=1, busy=0. start from DONE/ERR clears flags -> POLL_REQ.
//  mem_req stays high through REQ states until gnt; no address/ReadEn without gnt.
//  mem_gnt dropping in a WAIT state is legal (data already in flight).
//  Read latency 1 cycle; minimum per node = 3 cycles (REQ, WAIT, OUT) with gnt & ready high.
//  abort has priority over start and all transitions; same cycle start&abort -> IDLE.
//  Ext_ReadData bits [31:5] ignored for nodes.
// STRUCTURE
//  Shared package: mailbox address constants (SP/EP/LEN/DONE/PATH offsets), FSM state encoding,
//   node width (5). The point-load controller uses the same constants.
//  No sub-module; single FSM plus idx, gap and poll counters.
// TESTING
//  done word=1 at first poll, len=3, nodes {4,9,17}, ready=1 -> 3 beats 4,9,17, last on 17, done=1.
//  done=0 for 5 polls then 1 -> exactly 6 reads at DONE_OFS spaced >=POLL_GAP+2 cycles.
//  len=0 -> done=1, node_valid never asserted; len=33 -> error=1, no node reads.
//  mem_gnt held low 10 cycles in NODE_REQ -> mem_req high, ReadEn low, no address change.
//  node_ready low 5 cycles on node 2 -> node_data stable, no extra memory reads.
//  abort / reset_n low mid-NODE_OUT -> IDLE, all outputs 0; done never polled -> error after MAX_POLLS.

Source files
------------

// File: rtl/path_readback_ctrl_pkg.sv
// Mailbox map and FSM encoding shared by the path readback and point-load controllers.
// The CPU mailbox sits at BASE_ADR. Path node i is at BASE_ADR + PATH_OFS + 4*i.
package path_readback_ctrl_pkg;

    localparam logic [31:0] BASE_ADR = 32'h0200_0000;
    localparam logic [31:0] SP_OFS   = 32'h0;
    localparam logic [31:0] EP_OFS   = 32'h4;
    localparam logic [31:0] LEN_OFS  = 32'h8;
    localparam logic [31:0] DONE_OFS = 32'hC;
    localparam logic [31:0] PATH_OFS = 32'h10;

    localparam int MAX_NODES = 32;
    localparam int POLL_GAP  = 16;
    localparam int MAX_POLLS = 1024;
    localparam int NODE_W    = 5;
    localparam int LEN_W     = 6;
    localparam int IDX_W     = 5;
    localparam int POLL_W    = 11;
    localparam int GAP_W     = 5;

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POLL_REQ  = 4'd1,
        ST_POLL_WAIT = 4'd2,
        ST_GAP       = 4'd3,
        ST_LEN_REQ   = 4'd4,
        ST_LEN_WAIT  = 4'd5,
        ST_NODE_REQ  = 4'd6,
        ST_NODE_WAIT = 4'd7,
        ST_NODE_OUT  = 4'd8,
        ST_DONE      = 4'd9,
        ST_ERR       = 4'd10
    } prc_state_e;

    function automatic logic [31:0] node_adr(input logic [IDX_W-1:0] idx);
        return BASE_ADR + PATH_OFS + {25'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/path_readback_ctrl_if.sv
// Bundles the external memory port (req/gnt plus read strobe) and the node output stream.
interface path_readback_ctrl_if
    import path_readback_ctrl_pkg::*;
();
    logic              mem_req;
    logic              mem_gnt;
    logic              Ext_ReadEn;
    logic [31:0]       Ext_DataAdr;
    logic [31:0]       Ext_ReadData;
    logic              node_valid;
    logic              node_ready;
    logic [NODE_W-1:0] node_data;
    logic              node_last;

    modport master (
        output mem_req, Ext_ReadEn, Ext_DataAdr, node_valid, node_data, node_last,
        input  mem_gnt, Ext_ReadData, node_ready
    );

    modport slave (
        input  mem_req, Ext_ReadEn, Ext_DataAdr, node_valid, node_data, node_last,
        output mem_gnt, Ext_ReadData, node_ready
    );
endinterface

// File: rtl/path_readback_ctrl.sv
// Polls the CPU done word, reads the path length and streams each path node downstream.
// state     | meaning
// IDLE      | waiting for start          POLL_REQ/WAIT | read done word
// GAP       | back off between polls     LEN_REQ/WAIT  | read path length
// NODE_REQ/WAIT | read node idx          NODE_OUT      | present node until accepted
// DONE/ERR  | finished ok / timeout or bad length
module path_readback_ctrl
    import path_readback_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_abort,
    path_readback_ctrl_if.master bus,
    output logic [LEN_W-1:0] o_path_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    prc_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [POLL_W-1:0] r_poll_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [LEN_W-1:0]  r_path_len;
    logic [NODE_W-1:0] r_node_data;

    logic              w_mem_req;
    logic              w_rd_en;
    logic [31:0]       w_req_adr;
    logic              w_last;
    logic              w_rd_zero;

    assign w_last    = ({1'b0, r_idx} == (r_path_len - 6'd1));
    assign w_rd_zero = (bus.Ext_ReadData == 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_req_adr   = 32'd0;
        unique case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_POLL_REQ;
            ST_POLL_REQ: begin
                w_mem_req = 1'b1;
                w_req_adr = BASE_ADR + DONE_OFS;
                if (bus.mem_gnt) w_state_nxt = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (!w_rd_zero)                   w_state_nxt = ST_LEN_REQ;
                else if (r_poll_cnt == POLL_LAST) w_state_nxt = ST_ERR;
                else                              w_state_nxt = ST_GAP;
            end
            ST_GAP: if (r_gap_cnt == '0) w_state_nxt = ST_POLL_REQ;
            ST_LEN_REQ: begin
                w_mem_req = 1'b1;
                w_req_adr = BASE_ADR + LEN_OFS;
                if (bus.mem_gnt) w_state_nxt = ST_LEN_WAIT;
            end
            ST_LEN_WAIT: begin
                if (w_rd_zero)                                   w_state_nxt = ST_DONE;
                else if (bus.Ext_ReadData > 32'(MAX_NODES)) w_state_nxt = ST_ERR;
                else                                             w_state_nxt = ST_NODE_REQ;
            end
            ST_NODE_REQ: begin
                w_mem_req = 1'b1;
                w_req_adr = node_adr(r_idx);
                if (bus.mem_gnt) w_state_nxt = ST_NODE_WAIT;
            end
            ST_NODE_WAIT: w_state_nxt = ST_NODE_OUT;
            ST_NODE_OUT: if (bus.node_ready) w_state_nxt = w_last ? ST_DONE : ST_NODE_REQ;
            ST_DONE, ST_ERR: if (i_start) w_state_nxt = ST_POLL_REQ;
            default: w_state_nxt = ST_IDLE;
        endcase
        // abort wins over every other transition, including a same-cycle start
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_mem_req   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_poll_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_path_len  <= '0;
            r_node_data <= '0;
        end else if (i_abort) begin
            r_idx       <= '0;
            r_poll_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_path_len  <= '0;
            r_node_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: if (i_start) r_poll_cnt <= '0;
                ST_POLL_WAIT: begin
                    if (w_rd_zero) begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                        r_gap_cnt  <= GAP_LOAD;
                    end
                end
                ST_GAP: if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
                ST_LEN_WAIT: begin
                    r_path_len <= bus.Ext_ReadData[LEN_W-1:0];
                    r_idx      <= '0;
                end
                ST_NODE_WAIT: r_node_data <= bus.Ext_ReadData[NODE_W-1:0];
                ST_NODE_OUT: if (bus.node_ready && !w_last) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign w_rd_en         = w_mem_req & bus.mem_gnt;
    assign bus.mem_req     = w_mem_req;
    assign bus.Ext_ReadEn  = w_rd_en;
    assign bus.Ext_DataAdr = w_rd_en ? w_req_adr : 32'd0;
    assign bus.node_valid  = (r_state == ST_NODE_OUT);
    assign bus.node_last   = (r_state == ST_NODE_OUT) & w_last;
    assign bus.node_data   = r_node_data;

    assign o_path_len = r_path_len;
    assign o_done     = (r_state == ST_DONE);
    assign o_error    = (r_state == ST_ERR);
    assign o_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);

endmodule

// File: tb/tb_path_readback_ctrl.sv
// Directed bench: behavioural mailbox memory, node sink with optional back-pressure, bus monitor.
module tb_path_readback_ctrl;
    import path_readback_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] path_len;
    logic       busy, done, error;

    path_readback_ctrl_if bus();

    path_readback_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (start),
        .i_abort    (abort),
        .bus        (bus),
        .o_path_len (path_len),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] mem [64];
    int          done_after = 0;
    logic        p_en = 1'b0;
    logic [31:0] p_adr = 32'd0;

    int          cyc = 0, n_polls = 0, n_node_reads = 0, n_viol = 0;
    int          n_beats = 0, n_valid_cyc = 0, n_unstable = 0;
    int          min_gap = 1000000, last_poll = 0;
    logic [4:0]  beat_data [32];
    logic        beat_last [32];
    int          beat_cyc  [32];
    logic        stalled = 1'b0;
    logic [4:0]  held = 5'd0;

    // bus monitor and request capture, all sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        p_en  = bus.Ext_ReadEn;
        p_adr = bus.Ext_DataAdr;
        if (start) begin
            n_polls = 0; n_node_reads = 0; n_viol = 0; n_beats = 0;
            n_valid_cyc = 0; n_unstable = 0; min_gap = 1000000; last_poll = 0;
        end
        if (bus.Ext_ReadEn) begin
            if (bus.mem_gnt !== 1'b1) n_viol++;
            if (bus.Ext_DataAdr == BASE_ADR + DONE_OFS) begin
                n_polls++;
                if (n_polls > 1 && (cyc - last_poll) < min_gap) min_gap = cyc - last_poll;
                last_poll = cyc;
            end
            if (bus.Ext_DataAdr >= BASE_ADR + PATH_OFS &&
                bus.Ext_DataAdr <  BASE_ADR + PATH_OFS + 32'd128) n_node_reads++;
        end else if (bus.Ext_DataAdr != 32'd0) begin
            n_viol++;
        end
        if (bus.node_valid) n_valid_cyc++;
        if (bus.node_valid && bus.node_ready && n_beats < 32) begin
            beat_data[n_beats] = bus.node_data;
            beat_last[n_beats] = bus.node_last;
            beat_cyc[n_beats]  = cyc;
            n_beats++;
        end
        if (bus.node_valid && !bus.node_ready) begin
            if (stalled && bus.node_data != held) n_unstable++;
            held    = bus.node_data;
            stalled = 1'b1;
        end else begin
            stalled = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (p_en) begin
            if (p_adr == BASE_ADR + DONE_OFS)
                bus.Ext_ReadData <= (n_polls > done_after) ? 32'd1 : 32'd0;
            else
                bus.Ext_ReadData <= mem[p_adr[7:2]];
        end else begin
            bus.Ext_ReadData <= 32'hDEAD_BEEF;
        end
    end

    int   stall_beat = -1, stall_len = 0, stall_cnt = 0;
    logic rdy_hold = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!busy) stall_cnt = 0;
        if (rdy_hold) begin
            bus.node_ready = 1'b0;
        end else if (bus.node_valid && n_beats == stall_beat && stall_cnt < stall_len) begin
            bus.node_ready = 1'b0;
            stall_cnt++;
        end else begin
            bus.node_ready = 1'b1;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int k = 0;
        while (!(done || error) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done | error), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!bus.node_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(bus.node_valid), 32'd1);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [19:0] exp_d);
        logic [19:0] d;
        d = exp_d;
        check($sformatf("%s_beats", tag), 32'(n_beats), 32'(n));
        for (int i = 0; i < n && i < n_beats; i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(beat_data[i]), 32'(d[i*5 +: 5]));
            check($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'(i == n - 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 32'({busy, done, error, bus.mem_req, bus.Ext_ReadEn,
                                    bus.node_valid, bus.node_last}), 32'd0);
        check({tag, "_len"},  32'(path_len), 32'd0);
        check({tag, "_node"}, 32'(bus.node_data), 32'd0);
        check({tag, "_adr"},  bus.Ext_DataAdr, 32'd0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        bus.mem_gnt = 1'b1;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1 reset_n = 1'b1;

        // three nodes, high bits of node words carry junk
        mem[2] = 32'd3;
        mem[4] = 32'hABCD_0004;
        mem[5] = 32'hFFFF_FFE9;
        mem[6] = 32'h0000_0031;
        done_after = 0;
        pulse_start();
        wait_end("t1_end", 200);
        check("t1_done", 32'({done, error, busy}), 32'b100);
        check("t1_len", 32'(path_len), 32'd3);
        check("t1_polls", 32'(n_polls), 32'd1);
        check("t1_node_reads", 32'(n_node_reads), 32'd3);
        check_beats("t1", 3, {5'd0, 5'd17, 5'd9, 5'd4});
        check("t1_rate01", 32'(beat_cyc[1] - beat_cyc[0]), 32'd3);
        check("t1_rate12", 32'(beat_cyc[2] - beat_cyc[1]), 32'd3);
        check("t1_viol", 32'(n_viol), 32'd0);

        // five empty polls before done
        done_after = 5;
        pulse_start();
        @(negedge clk);
        check("t2_flags_clr", 32'({done, error, busy}), 32'b001);
        wait_end("t2_end", 400);
        check("t2_done", 32'(done), 32'd1);
        check("t2_polls", 32'(n_polls), 32'd6);
        check("t2_gap", 32'(min_gap >= POLL_GAP + 2), 32'd1);
        check_beats("t2", 3, {5'd0, 5'd17, 5'd9, 5'd4});

        done_after = 0;
        mem[2] = 32'd0;
        pulse_start();
        wait_end("t3_end", 200);
        check("t3_done", 32'({done, error}), 32'b10);
        check("t3_valid", 32'(n_valid_cyc), 32'd0);
        check("t3_node_reads", 32'(n_node_reads), 32'd0);
        check("t3_len", 32'(path_len), 32'd0);

        mem[2] = 32'd33;
        pulse_start();
        wait_end("t4_end", 200);
        check("t4_err", 32'({done, error}), 32'b01);
        check("t4_node_reads", 32'(n_node_reads), 32'd0);
        check("t4_len", 32'(path_len), 32'd33);

        // grant withheld while node 1 is requested
        mem[2] = 32'd3; mem[4] = 32'd1; mem[5] = 32'd2; mem[6] = 32'd3;
        pulse_start();
        wait_valid("t5_first_valid", 200);
        @(posedge clk); #1 bus.mem_gnt = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(bus.mem_req === 1'b1 && bus.Ext_ReadEn === 1'b0 &&
                  bus.Ext_DataAdr === 32'd0 && busy === 1'b1)) bad++;
        end
        check("t5_gnt_hold", 32'(bad), 32'd0);
        check("t5_reads_held", 32'(n_node_reads), 32'd1);
        @(posedge clk); #1 bus.mem_gnt = 1'b1;
        wait_end("t5_end", 200);
        check_beats("t5", 3, {5'd0, 5'd3, 5'd2, 5'd1});
        check("t5_viol", 32'(n_viol), 32'd0);

        // back-pressure on the second node
        mem[2] = 32'd4; mem[4] = 32'd5; mem[5] = 32'd6; mem[6] = 32'd7; mem[7] = 32'd8;
        stall_beat = 1; stall_len = 5;
        pulse_start();
        wait_end("t6_end", 200);
        check_beats("t6", 4, {5'd8, 5'd7, 5'd6, 5'd5});
        check("t6_valid_cyc", 32'(n_valid_cyc), 32'd9);
        check("t6_stable", 32'(n_unstable), 32'd0);
        check("t6_node_reads", 32'(n_node_reads), 32'd4);
        stall_beat = -1; stall_len = 0;

        rdy_hold = 1'b1;
        pulse_start();
        wait_valid("t7_valid", 200);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check_all_zero("t7_abort");
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        check("t7_start_abort", 32'({busy, bus.mem_req}), 32'd0);

        pulse_start();
        wait_valid("t8_valid", 200);
        #2 reset_n = 1'b0;
        #1 check_all_zero("t8_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        rdy_hold = 1'b0;
        @(negedge clk);
        check("t8_idle", 32'({busy, done, error}), 32'd0);

        // done word never set
        done_after = 1 << 30;
        pulse_start();
        wait_end("t9_end", 25000);
        check("t9_err", 32'({done, error}), 32'b01);
        check("t9_polls", 32'(n_polls), 32'(MAX_POLLS));
        check("t9_node_reads", 32'(n_node_reads), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
